fetch_pc_unit: RTL and testbench

- Program-counter and fetch-sequencing stage directly upstream of the instruction ROM.
- Its prog_ctr output drives the ROM address. The ROM's 9-bit mach_code goes to the decoder, which returns jump, branch, stall and halt controls to this block.
- Holds an 8-entry programmable branch-target lookup table (LUT), because 9-bit instructions cannot carry a full 12-bit target.
- Runs a start/done handshake with the testbench or top level, and counts executed instructions.

---
 rtl/fetch_pc_unit.sv | 123 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer feeding the instruction ROM.
// Holds the branch-target LUT, runs the start/done handshake and counts
// instructions advanced since the last start.
module fetch_pc_unit #(
  parameter int unsigned D          = 12,
  parameter int unsigned LUT_W      = 3,
  parameter int unsigned OFF_W      = 6,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             jump_en,
  input  logic [LUT_W-1:0] target_idx,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] rel_offset,
  input  logic             lut_we,
  input  logic [LUT_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_ct
);

  localparam int unsigned LUT_N = 1 << LUT_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [D-1:0]     PC_START = D'(START_ADDR);
  localparam logic [D-1:0]     PC_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [D-1:0]     pc_nxt;
  logic [CNT_W-1:0] ct_nxt;
  logic [CNT_W-1:0] ct_inc;
  logic [D-1:0]     off_ext;
  logic [D-1:0]     lut [LUT_N];

  // Saturating increment of the executed-instruction count
  assign ct_inc  = (instr_ct == CNT_MAX) ? instr_ct : instr_ct + CNT_W'(1);

  // Sign-extended branch offset; D-bit addition gives modulo-2**D wrap
  assign off_ext = {{(D-OFF_W){rel_offset[OFF_W-1]}}, rel_offset};

  // Next state, next PC and next count; start overrides everything
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    ct_nxt    = instr_ct;
    if (start) begin
      state_nxt = ST_RUN;
      pc_nxt    = PC_START;
      ct_nxt    = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state_nxt = ST_HALT;
            ct_nxt    = ct_inc;
          end else if (stall) begin
            // decoder re-presents jump/branch once the stall drops
          end else if (jump_en) begin
            pc_nxt = lut[target_idx];
            ct_nxt = ct_inc;
          end else if (branch_en) begin
            pc_nxt = prog_ctr + off_ext;
            ct_nxt = ct_inc;
          end else if (prog_ctr == PC_MAX) begin
            // runaway guard: falling off the end of the ROM stops execution
            state_nxt = ST_HALT;
          end else begin
            pc_nxt = prog_ctr + D'(1);
            ct_nxt = ct_inc;
          end
        end
        ST_IDLE: begin
          pc_nxt = PC_START;
        end
        ST_HALT: begin
        end
        default: begin
          state_nxt = ST_IDLE;
          pc_nxt    = PC_START;
        end
      endcase
    end
  end

  // Sequencer state, PC, counter and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      prog_ctr <= PC_START;
      instr_ct <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      instr_ct <= ct_nxt;
      running  <= (state_nxt == ST_RUN);
      done     <= (state_nxt == ST_HALT);
    end
  end

  // Branch-target LUT; a same-cycle jump reads the pre-write entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LUT_N); i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random
// stimulus compared against an arithmetic reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, halt, jump_en, branch_en, lut_we;
  logic [2:0]  target_idx, lut_waddr;
  logic [5:0]  rel_offset;
  logic [11:0] lut_wdata;
  logic [11:0] prog_ctr;
  logic        running, done;
  logic [15:0] instr_ct;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 run, 2 halted
  int m_state, m_pc, m_ct;
  int m_lut [8];

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .jump_en(jump_en), .target_idx(target_idx), .branch_en(branch_en),
    .rel_offset(rel_offset), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .prog_ctr(prog_ctr), .running(running),
    .done(done), .instr_ct(instr_ct)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_ct    = 0;
    for (int i = 0; i < 8; i++) m_lut[i] = 0;
  endtask

  task automatic bump();
    if (m_ct < 65535) m_ct++;
  endtask

  // One clock edge of the specified behaviour, on the inputs as sampled
  task automatic model_step();
    int tgt;
    int off;
    tgt = m_lut[target_idx];
    off = int'(rel_offset);
    if (off >= 32) off -= 64;
    if (start) begin
      m_state = 1; m_pc = 0; m_ct = 0;
    end else if (m_state == 1) begin
      if (halt) begin
        m_state = 2; bump();
      end else if (stall) begin
        m_pc = m_pc;
      end else if (jump_en) begin
        m_pc = tgt; bump();
      end else if (branch_en) begin
        m_pc = ((m_pc + off) % 4096 + 4096) % 4096; bump();
      end else if (m_pc == 4095) begin
        m_state = 2;
      end else begin
        m_pc = m_pc + 1; bump();
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic check_all();
    check("pc",       32'(prog_ctr), 32'(m_pc));
    check("running",  32'(running),  32'(m_state == 1));
    check("done",     32'(done),     32'(m_state == 2));
    check("instr_ct", 32'(instr_ct), 32'(m_ct));
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; jump_en = 0; branch_en = 0; lut_we = 0;
    target_idx = 0; lut_waddr = 0; rel_offset = 0; lut_wdata = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Restart, then jump through LUT[7] to reach address p (instr_ct ends at 1)
  task automatic goto_pc(input logic [11:0] p);
    clear_inputs();
    start = 1; lut_we = 1; lut_waddr = 3'd7; lut_wdata = p;
    cycle();
    clear_inputs();
    jump_en = 1; target_idx = 3'd7;
    cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1;
    #2;
    check_all();
    @(posedge clk); #3;
    reset = 0;

    // Idle ignores controls other than start
    jump_en = 1; branch_en = 1; halt = 1;
    cycle();
    clear_inputs();

    // Start then free-run
    start = 1;
    cycle();
    check("start_pc", 32'(prog_ctr), 32'h0);
    start = 0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check("seq_pc", 32'(prog_ctr), 32'(i));
    end
    check("seq_ct", 32'(instr_ct), 32'd4);
    check("seq_run", 32'(running), 32'd1);

    // LUT write then jump from PC 5
    lut_we = 1; lut_waddr = 3'd3; lut_wdata = 12'h2A0;
    cycle();
    clear_inputs();
    check("pc5", 32'(prog_ctr), 32'h5);
    jump_en = 1; target_idx = 3'd3;
    cycle();
    check("jump_lut3", 32'(prog_ctr), 32'h2A0);

    // Same-cycle write and jump: old entry used
    goto_pc(12'h050);
    jump_en = 1; target_idx = 3'd3; lut_we = 1; lut_waddr = 3'd3; lut_wdata = 12'h111;
    cycle();
    check("jump_old", 32'(prog_ctr), 32'h2A0);
    clear_inputs();
    jump_en = 1; target_idx = 3'd3;
    cycle();
    check("jump_new", 32'(prog_ctr), 32'h111);
    clear_inputs();

    // Relative branches with wrap
    goto_pc(12'h004);
    branch_en = 1; rel_offset = 6'(-6);
    cycle();
    check("br_neg_wrap", 32'(prog_ctr), 32'hFFE);
    rel_offset = 6'd4;
    cycle();
    check("br_pos_wrap", 32'(prog_ctr), 32'h002);
    goto_pc(12'h010);
    branch_en = 1; rel_offset = 6'd31;
    cycle();
    check("br_31", 32'(prog_ctr), 32'h02F);
    jump_en = 1; target_idx = 3'd3;
    cycle();
    check("jump_beats_br", 32'(prog_ctr), 32'h111);
    clear_inputs();

    // Stall holds, then the pending jump is taken
    lut_we = 1; lut_waddr = 3'd1; lut_wdata = 12'h0AB;
    cycle();
    goto_pc(12'h007);
    stall = 1; jump_en = 1; target_idx = 3'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_pc", 32'(prog_ctr), 32'h7);
      check("stall_ct", 32'(instr_ct), 32'd1);
    end
    stall = 0;
    cycle();
    check("post_stall_jump", 32'(prog_ctr), 32'h0AB);
    clear_inputs();

    // Halt wins over jump and freezes everything
    goto_pc(12'h007);
    halt = 1; jump_en = 1; target_idx = 3'd1;
    cycle();
    check("halt_done", 32'(done), 32'd1);
    check("halt_pc", 32'(prog_ctr), 32'h7);
    halt = 0; branch_en = 1; rel_offset = 6'd9; stall = 1;
    for (int i = 0; i < 3; i++) cycle();
    check("halt_frozen", 32'(prog_ctr), 32'h7);
    clear_inputs();

    // Runaway guard at the top of the address space
    goto_pc(12'hFFD);
    cycle();
    cycle();
    check("top_pc", 32'(prog_ctr), 32'hFFF);
    cycle();
    check("guard_done", 32'(done), 32'd1);
    check("guard_run", 32'(running), 32'd0);
    check("guard_pc", 32'(prog_ctr), 32'hFFF);
    cycle();
    start = 1;
    cycle();
    check("restart_pc", 32'(prog_ctr), 32'h0);
    check("restart_done", 32'(done), 32'd0);
    check("restart_ct", 32'(instr_ct), 32'd0);
    clear_inputs();

    // Asynchronous reset between edges
    goto_pc(12'h020);
    cycle();
    cycle();
    #2;
    reset = 1;
    #1;
    model_reset();
    check("async_pc", 32'(prog_ctr), 32'h0);
    check("async_run", 32'(running), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_ct", 32'(instr_ct), 32'd0);
    #1;
    reset = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("post_reset_idle", 32'(prog_ctr), 32'h0);

    // Counter saturation: self-loop jump at PC 0 through a zeroed LUT[0]
    start = 1;
    cycle();
    clear_inputs();
    jump_en = 1; target_idx = 3'd0;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      model_step();
      #1;
    end
    check_all();
    check("ct_saturated", 32'(instr_ct), 32'hFFFF);
    clear_inputs();

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      start      = ($urandom_range(0, 99) < 2);
      halt       = ($urandom_range(0, 99) < 3);
      stall      = ($urandom_range(0, 99) < 20);
      jump_en    = ($urandom_range(0, 99) < 15);
      branch_en  = ($urandom_range(0, 99) < 20);
      lut_we     = ($urandom_range(0, 99) < 25);
      target_idx = 3'($urandom);
      lut_waddr  = 3'($urandom);
      rel_offset = 6'($urandom);
      lut_wdata  = ($urandom_range(0, 3) == 0) ? 12'hFF0 + 12'($urandom_range(0, 15)) : 12'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
